mem_bus_ctrl: RTL
=================

// Module: mem_bus_ctrl
// PURPOSE
//  Memory-side bus controller directly downstream of the multi-cycle CPU datapath/control unit.
//  Serves two requesters: instruction fetch (i_*) and load/store (d_*). Fixed priority: data wins.
//  Drives the external readM/writeM/address/data (inout) memory bus for a fixed MEM_LATENCY.
//  Returns read data with a one-cycle ack pulse. Keeps read/write access counters for bring-up.
// PARAMETERS
//  WORD_SIZE    16  bus/address/data width (matches `WORD_SIZE)
//  MEM_LATENCY  2   cycles readM/writeM held per access; legal range >=1
//  CNT_WIDTH    16  width of rd_count/wr_count
// PORTS
//  clk       in   1          single clock, all logic on posedge
//  reset     in   1          synchronous, active-high
//  i_req     in   1          fetch request, level; held with i_addr stable until i_ack
//  i_addr    in   WORD_SIZE  fetch address
//  i_ack     out  1          1-cycle pulse; i_rdata valid in the same cycle
//  i_rdata   out  WORD_SIZE  fetched word (registered, holds until next fetch ack)
//  d_req     in   1          data request, level; held with d_we/d_addr/d_wdata stable until d_ack
//  d_we      in   1          1=write, 0=read
//  d_addr    in   WORD_SIZE  data address
//  d_wdata   in   WORD_SIZE  store data
//  d_ack     out  1          1-cycle pulse; d_rdata valid in the same cycle (reads)
//  d_rdata   out  WORD_SIZE  load data (registered, holds until next data read ack)
//  readM     out  1          memory read strobe
//  writeM    out  1          memory write strobe
//  address   out  WORD_SIZE  memory address (registered)
//  data      inout WORD_SIZE driven only while writeM=1, else 'bz
//  busy      out  1          1 in any state other than IDLE
//  rd_count  out  CNT_WIDTH  completed reads (both ports), wraps modulo 2^CNT_WIDTH
//  wr_count  out  CNT_WIDTH  completed writes, wraps modulo 2^CNT_WIDTH
// BEHAVIOUR
//  - Reset values: readM=0, writeM=0, address=0, data=Z, i_ack=d_ack=0.
//    Also i_rdata=d_rdata=0, busy=0, counters=0, state=IDLE.
//  - FSM: IDLE -> ACCESS (L=MEM_LATENCY cycles) -> RESP (1 cycle) -> IDLE.
//  - IDLE: sample requests. If d_req, accept data (latch we/addr/wdata).
//    Else if i_req, accept fetch. Else stay in IDLE.
//  - Timing, request seen in IDLE cycle 0:
//    ACCESS cycles 1..L with readM or writeM=1 and address=latched addr;
//    ack in cycle L+1 (RESP); IDLE again in cycle L+2.
//  - Read: data sampled at the clock edge ending the last ACCESS cycle, into i_rdata/d_rdata.
//  - Write: data bus driven with latched wdata only during ACCESS cycles.
//  - RESP: requests are ignored. The requester drops req in the cycle after ack.
//    A req still high in IDLE is treated as a new request.
//  - Throughput: one access per L+2 cycles. A pending fetch waits behind any data request.
//    No starvation guarantee (the CPU never issues both continuously).
//  - address holds its last value after an access. readM and writeM are never both 1.
//  - Counters increment on the ack cycle edge. They wrap silently.
//  - Latency counter counts L-1 down to 0 and is reloaded on accept.
//  - Sync reset at any point, including mid-ACCESS, gives these values after the next edge:
//    IDLE, strobes 0, bus Z, no ack for the aborted access, counters cleared.
//  - Requests asserted while reset=1 are not accepted.
// STRUCTURE
//  - Shared header.v: `WORD_SIZE, and state encodings `MBC_IDLE/`MBC_ACCESS/`MBC_RESP (2 bits).
//  - One sub-module: mbc_arbiter. Combinational fixed-priority grant (d over i) plus a
//    registered grant-select used to route rdata/ack.
//  - Top keeps the FSM, latency counter, bus drivers and counters.
// TESTING (MEM_LATENCY=2 unless stated; memory model responds combinationally)
//  1. Write: d_req, we=1, addr 0x0010, wdata 0xBEEF.
//     -> writeM=1 in cycles 1-2 with address=0x0010 and data=0xBEEF;
//     data=Z otherwise; d_ack in cycle 3; wr_count=1.
//  2. Fetch: i_req, addr 0x0004, memory holds 0x1234.
//     -> readM=1 in cycles 1-2; i_ack in cycle 3 with i_rdata=0x1234;
//     rd_count=1; d_ack stays 0.
//  3. Contention: i_req and d_req (read of 0x0020=0x5555) in the same cycle.
//     -> data first: d_ack in cycle 3 with 0x5555; fetch readM in cycles 5-6; i_ack in cycle 7.
//  4. Abort: reset=1 in cycle 2 of a read.
//     -> cycle 3: readM=0, busy=0, data=Z, no ack, rd_count=0; a new request completes normally.
//  5. Wrap: CNT_WIDTH=4, 16 back-to-back reads -> rd_count returns to 0; wr_count stays 0.
//  6. MEM_LATENCY=1: alternating write 0x0008=0x00FF then read 0x0008.
//     -> strobe 1 cycle each; ack 2 cycles after accept; d_rdata=0x00FF.

Source files
------------

// File: rtl/mem_bus_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl_pkg
//   Shared definitions for the memory-side bus controller:
//   - MBC_WORD_SIZE : default bus/address/data width
//   - mbc_state_e   : controller FSM state encoding (2 bits)
//   - latWidth()    : width of the latency down-counter for a given latency
// ---------------------------------------------------------------------------
package mem_bus_ctrl_pkg;

    localparam int MBC_WORD_SIZE = 16;

    typedef enum logic [1:0] {
        MBC_IDLE   = 2'd0,
        MBC_ACCESS = 2'd1,
        MBC_RESP   = 2'd2
    } mbc_state_e;

    // The counter holds values L-1 .. 0, so a latency of 1 still needs one bit.
    function automatic int latWidth(input int lat);
        return (lat > 1) ? $clog2(lat) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_ctrl_arbiter.sv
// ---------------------------------------------------------------------------
// mbc_arbiter
//   Fixed-priority arbiter between the fetch and load/store requesters.
//   Data requests always win. The grant is combinational; the winner of the
//   current access is remembered so the response can be routed back.
// Ports:
//   clk       in   clock
//   reset     in   synchronous active-high reset
//   iReq_i    in   fetch request
//   dReq_i    in   data request
//   accept_i  in   controller is accepting a new access this cycle
//   gntI_o    out  fetch would be granted
//   gntD_o    out  data would be granted
//   selD_o    out  current access belongs to the data port (registered)
// ---------------------------------------------------------------------------
module mbc_arbiter (
    input  logic clk,
    input  logic reset,
    input  logic iReq_i,
    input  logic dReq_i,
    input  logic accept_i,
    output logic gntI_o,
    output logic gntD_o,
    output logic selD_o
);

    logic selD_q;

    always_comb begin
        gntD_o = dReq_i;
        gntI_o = iReq_i & ~dReq_i;
    end

    // Grant-select is captured only when an access starts, so it stays
    // stable across the access and its response cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            selD_q <= 1'b0;
        end else if (accept_i) begin
            selD_q <= gntD_o;
        end
    end

    assign selD_o = selD_q;

endmodule

// File: rtl/mem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// mem_bus_ctrl
//   Memory-side bus controller serving an instruction-fetch port (i_*) and
//   a load/store port (d_*), data port having priority. Each access holds
//   readM/writeM for MEM_LATENCY cycles, then acks the requester for one
//   cycle. Read/write completion counters are kept for bring-up.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   i_req/i_addr        fetch request (level) and address
//   i_ack/i_rdata       fetch ack pulse and registered fetched word
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, store data
//   d_ack/d_rdata       data ack pulse and registered load data
//   readM/writeM        memory strobes
//   address             registered memory address
//   data                bidirectional memory data, driven only while writeM
//   busy                controller not idle
//   rd_count/wr_count   completed reads / writes, wrapping
// ---------------------------------------------------------------------------
module mem_bus_ctrl
    import mem_bus_ctrl_pkg::*;
#(
    parameter int WORD_SIZE   = MBC_WORD_SIZE,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_req,
    input  logic [WORD_SIZE-1:0] i_addr,
    output logic                 i_ack,
    output logic [WORD_SIZE-1:0] i_rdata,
    input  logic                 d_req,
    input  logic                 d_we,
    input  logic [WORD_SIZE-1:0] d_addr,
    input  logic [WORD_SIZE-1:0] d_wdata,
    output logic                 d_ack,
    output logic [WORD_SIZE-1:0] d_rdata,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    inout  wire  [WORD_SIZE-1:0] data,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] rd_count,
    output logic [CNT_WIDTH-1:0] wr_count
);

    localparam int              LAT_W      = latWidth(MEM_LATENCY);
    localparam logic [LAT_W-1:0] LAT_RELOAD = LAT_W'(MEM_LATENCY - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    mbc_state_e           state_q, state_d;
    logic [LAT_W-1:0]     latCnt_q, latCnt_d;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wData_q;
    logic [WORD_SIZE-1:0] iRData_q;
    logic [WORD_SIZE-1:0] dRData_q;
    logic [CNT_WIDTH-1:0] rdCount_q;
    logic [CNT_WIDTH-1:0] wrCount_q;

    logic gntI;
    logic gntD;
    logic selD;
    logic accept;
    logic lastAccess;

    mbc_arbiter u_arbiter (
        .clk      (clk),
        .reset    (reset),
        .iReq_i   (i_req),
        .dReq_i   (d_req),
        .accept_i (accept),
        .gntI_o   (gntI),
        .gntD_o   (gntD),
        .selD_o   (selD)
    );

    assign accept     = (state_q == MBC_IDLE) && (gntD || gntI);
    assign lastAccess = (state_q == MBC_ACCESS) && (latCnt_q == '0);

    // Next-state logic: the latency counter is reloaded on accept and
    // counts down while in ACCESS; reaching zero ends the access.
    always_comb begin
        state_d  = state_q;
        latCnt_d = latCnt_q;
        case (state_q)
            MBC_IDLE: begin
                if (accept) begin
                    state_d  = MBC_ACCESS;
                    latCnt_d = LAT_RELOAD;
                end
            end
            MBC_ACCESS: begin
                if (latCnt_q == '0) begin
                    state_d = MBC_RESP;
                end else begin
                    latCnt_d = latCnt_q - LAT_W'(1);
                end
            end
            MBC_RESP: begin
                state_d = MBC_IDLE;
            end
            default: begin
                state_d = MBC_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= MBC_IDLE;
            latCnt_q <= '0;
        end else begin
            state_q  <= state_d;
            latCnt_q <= latCnt_d;
        end
    end

    // Request latching, read-data capture and completion counters. Read
    // data is taken at the edge that ends the last ACCESS cycle so it is
    // already registered when the ack appears.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q      <= 1'b0;
            addr_q    <= '0;
            wData_q   <= '0;
            iRData_q  <= '0;
            dRData_q  <= '0;
            rdCount_q <= '0;
            wrCount_q <= '0;
        end else begin
            if (accept) begin
                we_q    <= gntD ? d_we : 1'b0;
                addr_q  <= gntD ? d_addr : i_addr;
                wData_q <= d_wdata;
            end
            if (lastAccess && !we_q) begin
                if (selD) begin
                    dRData_q <= data;
                end else begin
                    iRData_q <= data;
                end
            end
            if (state_q == MBC_RESP) begin
                if (we_q) begin
                    wrCount_q <= wrCount_q + CNT_ONE;
                end else begin
                    rdCount_q <= rdCount_q + CNT_ONE;
                end
            end
        end
    end

    assign readM    = (state_q == MBC_ACCESS) && !we_q;
    assign writeM   = (state_q == MBC_ACCESS) && we_q;
    assign busy     = (state_q != MBC_IDLE);
    assign i_ack    = (state_q == MBC_RESP) && !selD;
    assign d_ack    = (state_q == MBC_RESP) && selD;
    assign address  = addr_q;
    assign i_rdata  = iRData_q;
    assign d_rdata  = dRData_q;
    assign rd_count = rdCount_q;
    assign wr_count = wrCount_q;

    assign data = writeM ? wData_q : {WORD_SIZE{1'bz}};

endmodule
